// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: maximal-length XNOR tap masks for widths 3..32 and a
// reference next-state function used by the core.
package lfsr_pkg;

   localparam int LFSR_MIN_W = 3;
   localparam int LFSR_MAX_W = 32;

   // Bit i set means state[i] feeds the XNOR; every mask has an even tap count,
   // so all-ones maps onto itself (the XNOR lockup state).
   localparam logic [31:0] LFSR_TAPS [LFSR_MIN_W:LFSR_MAX_W] = '{
      32'h0000_0006, 32'h0000_000C, 32'h0000_0014, 32'h0000_0030,  //  3.. 6
      32'h0000_0060, 32'h0000_00B8, 32'h0000_0110, 32'h0000_0240,  //  7..10
      32'h0000_0500, 32'h0000_0829, 32'h0000_100D, 32'h0000_2015,  // 11..14
      32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400,  // 15..18
      32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000,  // 19..22
      32'h0042_0000, 32'h00E1_0000, 32'h0120_0000, 32'h0200_0023,  // 23..26
      32'h0400_0013, 32'h0900_0000, 32'h1400_0000, 32'h2000_0029,  // 27..30
      32'h4800_0000, 32'h8020_0003                                 // 31..32
   };

   function automatic logic [31:0] lfsr_next(input logic [31:0] state, input int width);
      logic [31:0] mask;
      logic        fb;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      fb   = ~^(state & LFSR_TAPS[width]);
      return ((state << 1) | {31'd0, fb}) & mask;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with XNOR feedback and seed mux.
// Optional LFSR_LOCKUP_RECOVER_EN steers the all-ones lockup state back to zero.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             adv_i,
   input  logic [WIDTH-1:0] seed_i,
   output logic [WIDTH-1:0] seed_eff_o,
   output logic [WIDTH-1:0] state_o,
   output logic [WIDTH-1:0] next_o
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] next_raw;

   always_comb begin
      next_raw = WIDTH'(lfsr_next(32'(state_q), WIDTH));
`ifdef LFSR_LOCKUP_RECOVER_EN
      seed_eff_o = (seed_i == ALL_ONES) ? '0 : seed_i;
      next_o     = (state_q == ALL_ONES) ? '0 : next_raw;
`else
      seed_eff_o = seed_i;
      next_o     = next_raw;
`endif
      if (load_i)     state_d = seed_eff_o;
      else if (adv_i) state_d = next_o;
      else            state_d = state_q;
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= '0;
      else        state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/lfsr_gen.sv
// Stallable Fibonacci XNOR LFSR generator: valid/ready output, period counter, wrap pulse.
// Build option LFSR_LOCKUP_RECOVER_EN (see lfsr_core) removes the all-ones lockup.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int OUT_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_d,
   output logic             rnd_valid,
   input  logic             rnd_ready,
   output logic [OUT_W-1:0] rnd_q,
   output logic             wrap,
   output logic [31:0]      period_q
);

   if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W || OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_param
      $error("lfsr_gen: WIDTH must be 3..32 and OUT_W must be 1..WIDTH");
   end

   logic             adv, hit;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic [31:0]      step_q, step_d, step_inc;
   logic [31:0]      period_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] seed_eff, state, next_state;

   lfsr_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (seed_load),
      .adv_i      (adv),
      .seed_i     (seed_d),
      .seed_eff_o (seed_eff),
      .state_o    (state),
      .next_o     (next_state)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      adv      = en & ~seed_load & (~valid_q | rnd_ready);
      hit      = adv & (next_state == start_q);
      step_inc = (step_q == 32'hFFFF_FFFF) ? step_q : step_q + 32'd1;
      valid_d  = valid_q;
      wrap_d   = 1'b0;
      step_d   = step_q;
      period_d = period_q;
      start_d  = start_q;
      if (seed_load) begin
         valid_d = 1'b0;
         step_d  = '0;
         start_d = seed_eff;
      end else if (adv) begin
         valid_d = 1'b1;
         if (hit) begin
            wrap_d   = 1'b1;
            period_d = step_inc;
            step_d   = '0;
         end else begin
            step_d = step_inc;
         end
      end else if (valid_q && rnd_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
         step_q   <= '0;
         period_q <= '0;
         start_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         wrap_q   <= wrap_d;
         step_q   <= step_d;
         period_q <= period_d;
         start_q  <= start_d;
      end
   end

   assign rnd_valid = valid_q;
   assign wrap      = wrap_q;
   assign rnd_q     = state[OUT_W-1:0];

endmodule
